imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader.sv | 153 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a word count, payload words and a checksum over a byte
// stream, writes the words into instruction memory and holds the CPU meanwhile.
module imem_boot_loader #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_CHK, S_DONE, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_n_q, cnt_n_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [23:0]         word_buf_q, word_buf_d;
  logic [7:0]          csum_q, csum_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_waddr_q, mem_waddr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [15:0]         hdr_n;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_n_d     = cnt_n_q;
    byte_idx_d  = byte_idx_q;
    word_idx_d  = word_idx_q;
    word_buf_d  = word_buf_q;
    csum_d      = csum_q;
    tmo_d       = tmo_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    hdr_n       = {rx_data, cnt_n_q[7:0]};

    case (state_q)
      S_HDR, S_LOAD, S_CHK: begin
        tmo_d = rx_valid ? '0 : tmo_q + TMO_W'(1);
        if (!rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYC - 1))) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          if (state_q == S_HDR) begin
            if (!byte_idx_q[0]) begin
              cnt_n_d[7:0] = rx_data;
              byte_idx_d   = 2'd1;
            end else begin
              cnt_n_d[15:8] = rx_data;
              byte_idx_d    = 2'd0;
              state_d = ((hdr_n == 16'd0) || (hdr_n > 16'(DEPTH))) ? S_ERR : S_LOAD;
            end
          end else if (state_q == S_LOAD) begin
            csum_d     = csum_q + rx_data;
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0:    word_buf_d[7:0]   = rx_data;
              2'd1:    word_buf_d[15:8]  = rx_data;
              2'd2:    word_buf_d[23:16] = rx_data;
              default: begin
                mem_we_d    = 1'b1;
                mem_waddr_d = word_idx_q;
                mem_wdata_d = {rx_data, word_buf_q};
                word_idx_d  = word_idx_q + ADDR_W'(1);
                // last word written goes straight to checksum phase
                if (16'(word_idx_q) == (cnt_n_q - 16'd1)) state_d = S_CHK;
              end
            endcase
          end else begin
            state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
          end
        end
      end
      default: begin
        if (start) begin
          state_d    = S_HDR;
          cnt_n_d    = '0;
          byte_idx_d = '0;
          word_idx_d = '0;
          word_buf_d = '0;
          csum_d     = '0;
          tmo_d      = '0;
        end
      end
    endcase

    busy_d     = (state_d == S_HDR) || (state_d == S_LOAD) || (state_d == S_CHK);
    cpu_hold_d = busy_d || (state_d == S_ERR);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_n_q     <= '0;
      byte_idx_q  <= '0;
      word_idx_q  <= '0;
      word_buf_q  <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_n_q     <= cnt_n_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      word_buf_q  <= word_buf_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed scenarios plus randomized sessions, checked
// every cycle against a byte-queue model of a load session.
module tb_imem_boot_loader;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TMO    = 16;

  logic              clk, reset, start, rx_valid;
  logic [7:0]        rx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold, busy, done, err;

  int total = 0;
  int bad   = 0;

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Session model: status plus the queue of bytes accepted since start.
  localparam int M_IDLE = 0, M_RUN = 1, M_OK = 2, M_BAD = 3;
  int                m_stat  = M_IDLE;
  int                m_idle  = 0;
  logic [7:0]        m_q[$];
  logic              e_we    = 1'b0;
  logic [ADDR_W-1:0] e_waddr = '0;
  logic [31:0]       e_wdata = '0;

  function automatic void m_accept();
    int len, n, p, sum;
    len = m_q.size();
    if (len < 2) return;
    n = 32'(m_q[0]) + 256 * 32'(m_q[1]);
    if (len == 2) begin
      if (n == 0 || n > DEPTH) m_stat = M_BAD;
      return;
    end
    p = len - 2;
    if (p <= 4 * n) begin
      if (p % 4 == 0) begin
        e_we    = 1'b1;
        e_waddr = ADDR_W'(p / 4 - 1);
        e_wdata = {m_q[len-1], m_q[len-2], m_q[len-3], m_q[len-4]};
      end
    end else begin
      sum = 0;
      for (int i = 2; i < len - 1; i++) sum += 32'(m_q[i]);
      m_stat = ((sum % 256) == 32'(m_q[len-1])) ? M_OK : M_BAD;
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_stat = M_IDLE; m_idle = 0; m_q.delete();
      e_we = 1'b0; e_waddr = '0; e_wdata = '0;
    end else begin
      e_we = 1'b0;
      if (m_stat != M_RUN) begin
        if (start) begin m_stat = M_RUN; m_idle = 0; m_q.delete(); end
      end else if (rx_valid) begin
        m_idle = 0;
        m_q.push_back(rx_data);
        m_accept();
      end else begin
        m_idle++;
        if (m_idle >= TMO) m_stat = M_BAD;
      end
    end
  end

  always @(negedge clk) begin
    check("mem_we",    32'(mem_we),    32'(e_we));
    check("mem_waddr", 32'(mem_waddr), 32'(e_waddr));
    check("mem_wdata", mem_wdata,      e_wdata);
    check("busy",      32'(busy),      32'(m_stat == M_RUN));
    check("cpu_hold",  32'(cpu_hold),  32'(m_stat == M_RUN || m_stat == M_BAD));
    check("done",      32'(done),      32'(m_stat == M_OK));
    check("err",       32'(err),       32'(m_stat == M_BAD));
  end

  // Captured memory image and write count, for literal checks
  logic [31:0] cap_mem [DEPTH];
  int          wr_cnt = 0;
  always @(posedge clk) begin
    if (mem_we && !reset) begin
      cap_mem[mem_waddr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // One clock cycle of stimulus; entered and left at posedge+1
  task automatic cyc(input logic s, input logic v, input logic [7:0] d);
    start = s; rx_valid = v; rx_data = d;
    @(posedge clk); #1;
    start = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic put(input logic [7:0] d);
    cyc(1'b0, 1'b1, d);
  endtask

  task automatic put_word(input logic [31:0] w);
    put(w[7:0]); put(w[15:8]); put(w[23:16]); put(w[31:24]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic session(input int n, input bit good, input bit noisy, input int tmo_pos);
    logic [7:0] b[$];
    logic [7:0] s;
    int nb;
    s = 8'h00;
    b.push_back(8'(n));
    b.push_back(8'(n >> 8));
    nb = (n >= 1 && n <= DEPTH) ? 4 * n : 4;
    for (int i = 0; i < nb; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      b.push_back(r);
      s += r;
    end
    b.push_back(good ? s : (s ^ 8'(1 << $urandom_range(7, 0))));
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < b.size(); i++) begin
      int g;
      g = (i == tmo_pos) ? int'(TMO) + 2 : int'($urandom_range(noisy ? 3 : 0, 0));
      for (int k = 0; k < g; k++) cyc(noisy && ($urandom_range(7, 0) == 0), 1'b0, 8'h00);
      put(b[i]);
    end
    idle(2);
  endtask

  int w0;

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we",    32'(mem_we), 32'd0);
    check("rst_hold",  32'(cpu_hold), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    idle(2);

    // single word, checksum 0x14
    w0 = wr_cnt;
    cyc(1'b1, 1'b0, 8'h00);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_hold_run", 32'(cpu_hold), 32'd1);
    put(8'h01); put(8'h00); put_word(32'h12345678); put(8'h14);
    idle(2);
    check("t1_done", 32'(done), 32'd1);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_mem0", cap_mem[0], 32'h12345678);
    check("t1_writes", 32'(wr_cnt - w0), 32'd1);

    // three words back-to-back; payload byte sum is 0xB9
    w0 = wr_cnt;
    cyc(1'b1, 1'b0, 8'h00);
    put(8'h03); put(8'h00);
    put_word(32'h00000013); put_word(32'h00100093); put_word(32'hFFF00113);
    put(8'hB9);
    idle(1);
    check("t2_done", 32'(done), 32'd1);
    check("t2_mem1", cap_mem[1], 32'h00100093);
    check("t2_mem2", cap_mem[2], 32'hFFF00113);
    check("t2_writes", 32'(wr_cnt - w0), 32'd3);

    // wrong checksum, then a good retry
    cyc(1'b1, 1'b0, 8'h00);
    put(8'h03); put(8'h00);
    put_word(32'h00000013); put_word(32'h00100093); put_word(32'hFFF00113);
    put(8'hBA);
    idle(1);
    check("t3_err", 32'(err), 32'd1);
    check("t3_hold", 32'(cpu_hold), 32'd1);
    cyc(1'b1, 1'b0, 8'h00);
    put(8'h03); put(8'h00);
    put_word(32'h00000013); put_word(32'h00100093); put_word(32'hFFF00113);
    put(8'hB9);
    idle(1);
    check("t3_done", 32'(done), 32'd1);
    check("t3_err_clr", 32'(err), 32'd0);

    // header boundaries: N=0 and N=257
    w0 = wr_cnt;
    cyc(1'b1, 1'b0, 8'h00);
    put(8'h00); put(8'h00);
    check("t4_zero_err", 32'(err), 32'd1);
    idle(4);
    cyc(1'b1, 1'b0, 8'h00);
    put(8'h01); put(8'h01);
    check("t4_big_err", 32'(err), 32'd1);
    put_word(32'h01020304);
    idle(2);
    check("t4_writes", 32'(wr_cnt - w0), 32'd0);

    // timeout after 6 of 8 payload bytes
    w0 = wr_cnt;
    cyc(1'b1, 1'b0, 8'h00);
    put(8'h02); put(8'h00);
    put_word(32'hA1B2C3D4); put(8'h11); put(8'h22);
    idle(int'(TMO) - 1);
    check("t5_still_busy", 32'(busy), 32'd1);
    idle(1);
    check("t5_err", 32'(err), 32'd1);
    check("t5_writes", 32'(wr_cnt - w0), 32'd1);
    check("t5_mem0", cap_mem[0], 32'hA1B2C3D4);

    // reset while the write strobe is high
    w0 = wr_cnt;
    cyc(1'b1, 1'b0, 8'h00);
    put(8'h02); put(8'h00);
    put_word(32'h55667788);
    check("t6_we_pre", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_we_cut", 32'(mem_we), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_waddr", 32'(mem_waddr), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    put_word(32'h99AABBCC);
    idle(2);
    check("t6_writes", 32'(wr_cnt - w0), 32'd0);

    // start mid-session is ignored
    cyc(1'b1, 1'b0, 8'h00);
    put(8'h01); put(8'h00); put(8'h11); put(8'h22);
    cyc(1'b1, 1'b0, 8'h00);
    put(8'h33); put(8'h44); put(8'hAA);
    idle(1);
    check("t7_done", 32'(done), 32'd1);
    check("t7_mem0", cap_mem[0], 32'h44332211);

    // start with a byte in the same cycle: the byte is dropped
    cyc(1'b1, 1'b1, 8'h05);
    put(8'h01); put(8'h00); put_word(32'hCAFEF00D); put(8'hC5);
    idle(1);
    check("t8_done", 32'(done), 32'd1);
    check("t8_mem0", cap_mem[0], 32'hCAFEF00D);

    // randomized sessions
    for (int t = 0; t < 25; t++) begin
      int n;
      case ($urandom_range(9, 0))
        0:       n = 0;
        1:       n = int'(DEPTH) + 1 + int'($urandom_range(300, 0));
        default: n = int'($urandom_range(6, 1));
      endcase
      session(n, $urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
              ($urandom_range(5, 0) == 0) ? int'($urandom_range(6, 0)) : -1);
    end
    session(int'(DEPTH), 1'b1, 1'b0, -1);
    check("full_done", 32'(done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
